unidade_controle_multiciclo: RTL
================================

Name: unidade_controle_multiciclo

Overview:
- Multicycle main control FSM for the MIPS datapath, one instruction at a time: fetch, decode, execute, memory, writeback.
- Sits directly upstream of the ALU control decoder and drives its 2-bit ULAOp; also drives all datapath mux selects and write enables.
- Memory accesses use a ready handshake, so fetch and data access stall until the memory acknowledges.

Parameters:
- OPCODE_W, 6, opcode field width.
- STATE_W, 4, width of the state encoding exported on state_o.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  instruction opcode, taken from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory acknowledge for the current MemRead/MemWrite; may stay high.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ULASrcA  out  1  datapath controls.
- PCSource  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- ULASrcB  out  2  00 = regB, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- ULAOp  out  2  11 = add, 01 = subtract (branch compare), 00 = decode funct (R-type), 10 = immediate logic op.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  out  1  sticky unknown-opcode flag.
- state_o  out  STATE_W  current state, for debug and verification.

Behaviour:
- Reset is asynchronous on the falling edge of rst_n and forces state INIT. All outputs are 0 in INIT, including ULAOp=00 and state_o=0.
- Outputs are Moore, decoded from the current state. Exception: in states that wait on memory, the state's enables are qualified by mem_ready as listed below.
- Any output not listed for a state is 0.
- Encodings: INIT=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, R_COMPLETE=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12, TRAP=13.
- INIT: all outputs 0; go to FETCH unconditionally after one cycle.
- FETCH: MemRead=1, IorD=0, ULASrcA=0, ULASrcB=01, ULAOp=11, PCSource=00. IRWrite and PCWrite equal mem_ready. Hold in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ULASrcA=0, ULASrcB=11, ULAOp=11. Next state by opcode:
  - R-type 000000 -> EXECUTE
  - LW 100011 or SW 101011 -> MEM_ADDR
  - BEQ 000100 -> BRANCH
  - J 000010 -> JUMP
  - ADDI 001000 -> ADDI_EXEC
  - any other opcode -> TRAP
- MEM_ADDR: ULASrcA=1, ULASrcB=10, ULAOp=11. LW -> MEM_READ; SW -> MEM_WRITE. The opcode is re-sampled here; IR is stable.
- MEM_READ: MemRead=1, IorD=1. Hold while mem_ready=0; go to MEM_WB on mem_ready=1.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1 -> FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. instr_done equals mem_ready. Go to FETCH on mem_ready=1, otherwise hold.
- EXECUTE: ULASrcA=1, ULASrcB=00, ULAOp=00 -> R_COMPLETE.
- R_COMPLETE: RegDst=1, RegWrite=1, MemtoReg=0, instr_done=1 -> FETCH.
- BRANCH: ULASrcA=1, ULASrcB=00, ULAOp=01, PCWriteCond=1, PCSource=01, instr_done=1 -> FETCH. The datapath combines the zero flag.
- JUMP: PCWrite=1, PCSource=10, instr_done=1 -> FETCH.
- ADDI_EXEC: ULASrcA=1, ULASrcB=10, ULAOp=11 -> ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1 -> FETCH.
- TRAP: illegal_op=1, all write enables 0. Stays in TRAP until reset.
- Latency with mem_ready held high, counted from FETCH entry: R-type 4 cycles, ADDI 4, LW 5, SW 4, BEQ 3, J 3. Each wait cycle with mem_ready=0 adds exactly 1.
- Reset mid-instruction: state goes to INIT immediately, outputs drop to 0 asynchronously, and no partial write enable survives.
- MemRead and MemWrite are never both 1. RegWrite is never 1 in the same cycle as MemWrite.

Decomposition:
- Package unidade_controle_pkg holds:
  - the state enum
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ULAOp constants: ULAOP_ADD=11, ULAOP_SUB=01, ULAOP_FUNCT=00, ULAOP_IMM=10
  - ULASrcB and PCSource select constants
- One state-register process plus one combinational next-state/output process. No sub-module is needed.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> all outputs 0 and state_o=0. Release -> INIT then FETCH, with MemRead=1 and ULAOp=11 in FETCH.
- R-type, opcode=000000, mem_ready=1 -> state sequence 1,2,7,8. ULAOp=00 in EXECUTE; RegDst=1 and RegWrite=1 in R_COMPLETE; instr_done pulses once on cycle 4.
- LW with mem_ready low for 2 cycles in MEM_READ -> MEM_READ lasts 3 cycles with MemRead=1 and IorD=1. MEM_WB then asserts MemtoReg=1 and RegWrite=1. Total is 7 cycles.
- BEQ, opcode=000100 -> BRANCH with ULAOp=01, PCWriteCond=1, PCSource=01. J, opcode=000010 -> PCWrite=1, PCSource=10. Each takes 3 cycles.
- FETCH with mem_ready=0 for 4 cycles -> IRWrite=0 and PCWrite=0 throughout. On the cycle mem_ready=1, IRWrite=PCWrite=1 for exactly 1 cycle.
- Opcode 111111 -> TRAP and illegal_op=1, sticky across 10 cycles. Asserting rst_n=0 mid-MEM_WRITE drops MemWrite to 0 asynchronously.

Source files
------------

// File: rtl/unidade_controle_pkg.sv
// Shared types and constants for the multicycle MIPS main control unit:
// state encoding, opcode values and datapath select codes.
package unidade_controle_pkg;

    typedef enum logic [3:0] {
        S_INIT       = 4'd0,
        S_FETCH      = 4'd1,
        S_DECODE     = 4'd2,
        S_MEM_ADDR   = 4'd3,
        S_MEM_READ   = 4'd4,
        S_MEM_WB     = 4'd5,
        S_MEM_WRITE  = 4'd6,
        S_EXECUTE    = 4'd7,
        S_R_COMPLETE = 4'd8,
        S_BRANCH     = 4'd9,
        S_JUMP       = 4'd10,
        S_ADDI_EXEC  = 4'd11,
        S_ADDI_WB    = 4'd12,
        S_TRAP       = 4'd13
    } state_t;

    // Instruction opcodes understood by the control unit
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ULAOp codes handed to the ALU control decoder
    localparam logic [1:0] ULAOP_ADD   = 2'b11;
    localparam logic [1:0] ULAOP_SUB   = 2'b01;
    localparam logic [1:0] ULAOP_FUNCT = 2'b00;
    localparam logic [1:0] ULAOP_IMM   = 2'b10;

    // Second ALU operand select
    localparam logic [1:0] SRCB_REGB     = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Dispatch target after DECODE; unknown opcodes land in TRAP
    function automatic state_t decode_dispatch(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_RTYPE:     nxt = S_EXECUTE;
            OP_LW, OP_SW: nxt = S_MEM_ADDR;
            OP_BEQ:       nxt = S_BRANCH;
            OP_J:         nxt = S_JUMP;
            OP_ADDI:      nxt = S_ADDI_EXEC;
            default:      nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle main control FSM for the MIPS datapath. Moore outputs decoded
// from the current state; memory-wait states qualify their enables with
// mem_ready so a stalled access never commits.
module unidade_controle_multiciclo
    import unidade_controle_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                ULASrcA,
    output logic [1:0]          PCSource,
    output logic [1:0]          ULASrcB,
    output logic [1:0]          ULAOp,
    output logic                instr_done,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  state_o
);

    state_t state_q, state_d;

    // State register; reset drops straight to INIT without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode from the current state
    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ULASrcA     = 1'b0;
        PCSource    = PCSRC_ALU;
        ULASrcB     = SRCB_REGB;
        ULAOp       = ULAOP_FUNCT;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;

        case (state_q)
            S_INIT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC+4 is computed every cycle but only committed with the IR
                MemRead  = 1'b1;
                ULASrcB  = SRCB_FOUR;
                ULAOp    = ULAOP_ADD;
                PCSource = PCSRC_ALU;
                IRWrite  = mem_ready;
                PCWrite  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut
                ULASrcB = SRCB_IMM_SHL2;
                ULAOp   = ULAOP_ADD;
                state_d = decode_dispatch(opcode);
            end
            S_MEM_ADDR: begin
                ULASrcA = 1'b1;
                ULASrcB = SRCB_IMM;
                ULAOp   = ULAOP_ADD;
                state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                ULASrcA = 1'b1;
                ULASrcB = SRCB_REGB;
                ULAOp   = ULAOP_FUNCT;
                state_d = S_R_COMPLETE;
            end
            S_R_COMPLETE: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                // PC update is gated by the ALU zero flag in the datapath
                ULASrcA     = 1'b1;
                ULASrcB     = SRCB_REGB;
                ULAOp       = ULAOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDI_EXEC: begin
                ULASrcA = 1'b1;
                ULASrcB = SRCB_IMM;
                ULAOp   = ULAOP_ADD;
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                // Parked until reset; the flag stays up as long as we are here
                illegal_op = 1'b1;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign state_o = STATE_W'(state_q);

endmodule
